// File: rtl/gpu_trace_pkg.sv
// Shared trace record type, field widths and helpers for the trace arbiter.
// TRACE_TIMESTAMP_EN adds a 32-bit capture timestamp to every record.
package gpu_trace_pkg;
    localparam int WARP_W  = 8;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int SRC_W   = 3;
    localparam int TS_W    = 32;

    typedef struct packed {
        logic [SRC_W-1:0]   src;
        logic [WARP_W-1:0]  warp_oh;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]    ts;
`endif
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

    function automatic logic is_one_hot(input logic [WARP_W-1:0] v);
        return $countones(v) == 1;
    endfunction
endpackage

// File: rtl/trace_arbiter_if.sv
// Tap-side and log-side signal bundle of the trace arbiter.
// TRACE_TIMESTAMP_EN adds out_ts to the log side.
interface trace_arbiter_if #(
    parameter int N_SRC = 4
);
    import gpu_trace_pkg::*;

    logic [N_SRC-1:0]         tap_valid;
    logic [WARP_W*N_SRC-1:0]  tap_warp_oh;
    logic [INSTR_W*N_SRC-1:0] tap_instr;
    logic [PC_W*N_SRC-1:0]    tap_pc;

    // Taps are strobes with no backpressure. The log side transfers the head
    // when out_valid && out_ready; head data holds while out_valid && !out_ready.
    logic                     out_valid;
    logic                     out_ready;
    logic [SRC_W-1:0]         out_src;
    logic [WARP_W-1:0]        out_warp_oh;
    logic [INSTR_W-1:0]       out_instr;
    logic [PC_W-1:0]          out_pc;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]          out_ts;

    modport master (output tap_valid, tap_warp_oh, tap_instr, tap_pc, out_ready,
                    input  out_valid, out_src, out_warp_oh, out_instr, out_pc, out_ts);
    modport slave  (input  tap_valid, tap_warp_oh, tap_instr, tap_pc, out_ready,
                    output out_valid, out_src, out_warp_oh, out_instr, out_pc, out_ts);
`else
    modport master (output tap_valid, tap_warp_oh, tap_instr, tap_pc, out_ready,
                    input  out_valid, out_src, out_warp_oh, out_instr, out_pc);
    modport slave  (input  tap_valid, tap_warp_oh, tap_instr, tap_pc, out_ready,
                    output out_valid, out_src, out_warp_oh, out_instr, out_pc);
`endif
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered storage; read data is zero while empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 75
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // Full blocks a push even when a pop happens in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/trace_arbiter.sv
// Captures non-stallable trace taps into per-source slots, filters by warp,
// round-robin arbitrates into an output FIFO and counts losses. TRACE_TIMESTAMP_EN adds out_ts.
module trace_arbiter
    import gpu_trace_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_enable,
    input  logic [WARP_W-1:0]             cfg_warp_mask,
    trace_arbiter_if.slave                bus,
    output logic [CNT_W*N_SRC-1:0]        drop_cnt,
    output logic [CNT_W-1:0]              bad_oh_cnt,
    output logic [SRC_W-1:0]              o_dbg_rr_ptr,
    output logic [$clog2(FIFO_DEPTH):0]   o_dbg_fifo_count
);
    localparam int RR_W = $clog2(N_SRC);
    localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    trace_rec_t        r_slot [N_SRC];
    logic [N_SRC-1:0]  r_slot_v;
    logic [RR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_drop [N_SRC];
    logic [CNT_W-1:0]  r_bad;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   r_cycle;
`endif

    trace_rec_t        w_tap [N_SRC];
    logic [N_SRC-1:0]  w_pass;
    logic [N_SRC-1:0]  w_bad;
    logic [CNT_W-1:0]  w_bad_next;
    logic              w_grant_v;
    logic [RR_W-1:0]   w_grant_idx;
    logic [N_SRC-1:0]  w_grant_oh;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    trace_rec_t        w_head;

    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            w_tap[s]         = '0;
            w_tap[s].src     = SRC_W'(s);
            w_tap[s].warp_oh = bus.tap_warp_oh[WARP_W*s +: WARP_W];
            w_tap[s].instr   = bus.tap_instr[INSTR_W*s +: INSTR_W];
            w_tap[s].pc      = bus.tap_pc[PC_W*s +: PC_W];
`ifdef TRACE_TIMESTAMP_EN
            w_tap[s].ts      = r_cycle;
`endif
            w_bad[s]  = bus.tap_valid[s] && cfg_enable && !is_one_hot(w_tap[s].warp_oh);
            w_pass[s] = bus.tap_valid[s] && cfg_enable && is_one_hot(w_tap[s].warp_oh)
                        && ((w_tap[s].warp_oh & cfg_warp_mask) != '0);
        end
    end

    // Scan from r_rr_ptr; nothing is granted while the FIFO is full.
    always_comb begin : arb
        int idx;
        idx         = 0;
        w_grant_v   = 1'b0;
        w_grant_idx = '0;
        w_grant_oh  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!w_grant_v && !w_fifo_full && r_slot_v[idx]) begin
                w_grant_v       = 1'b1;
                w_grant_idx     = RR_W'(idx);
                w_grant_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_bad_next = r_bad;
        for (int s = 0; s < N_SRC; s++) begin
            if (w_bad[s]) w_bad_next = CNT_W'(sat_inc(32'(w_bad_next), CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_v <= '0;
            r_rr_ptr <= '0;
            r_bad    <= '0;
            for (int s = 0; s < N_SRC; s++) begin
                r_slot[s] <= '0;
                r_drop[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SRC; s++) begin
                // A slot granted this cycle frees up in time to take the new record.
                if (w_pass[s] && (!r_slot_v[s] || w_grant_oh[s])) begin
                    r_slot_v[s] <= 1'b1;
                    r_slot[s]   <= w_tap[s];
                end else if (w_grant_oh[s]) begin
                    r_slot_v[s] <= 1'b0;
                end
                if (w_pass[s] && r_slot_v[s] && !w_grant_oh[s])
                    r_drop[s] <= CNT_W'(sat_inc(32'(r_drop[s]), CNT_MAX));
            end
            if (w_grant_v)
                r_rr_ptr <= (w_grant_idx == RR_W'(N_SRC-1)) ? '0 : w_grant_idx + RR_W'(1);
            r_bad <= w_bad_next;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) r_cycle <= '0;
        else        r_cycle <= r_cycle + TS_W'(1);
    end
`endif

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_grant_v),
        .i_pop   (bus.out_ready),
        .i_wdata (r_slot[w_grant_idx]),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_dbg_fifo_count)
    );

    assign bus.out_valid   = !w_fifo_empty;
    assign bus.out_src     = w_head.src;
    assign bus.out_warp_oh = w_head.warp_oh;
    assign bus.out_instr   = w_head.instr;
    assign bus.out_pc      = w_head.pc;
`ifdef TRACE_TIMESTAMP_EN
    assign bus.out_ts      = w_head.ts;
`endif

    always_comb begin
        drop_cnt = '0;
        for (int s = 0; s < N_SRC; s++) drop_cnt[CNT_W*s +: CNT_W] = r_drop[s];
    end

    assign bad_oh_cnt   = r_bad;
    assign o_dbg_rr_ptr = SRC_W'(r_rr_ptr);
endmodule

// File: tb/tb_trace_arbiter.sv
// Directed and randomized bench for trace_arbiter against a queue-based reference model.
module tb_trace_arbiter;
    import gpu_trace_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int RW    = SRC_W + WARP_W + INSTR_W + PC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_enable = 1'b0;
    logic [7:0]        cfg_warp_mask = 8'h00;
    logic [CW*N-1:0]   drop_cnt;
    logic [CW-1:0]     bad_oh_cnt;
    logic [2:0]        dbg_rr;
    logic [3:0]        dbg_count;

    int tests = 0;
    int fails = 0;

    trace_arbiter_if #(.N_SRC(N)) bus();

    trace_arbiter #(.N_SRC(N), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_enable       (cfg_enable),
        .cfg_warp_mask    (cfg_warp_mask),
        .bus              (bus),
        .drop_cnt         (drop_cnt),
        .bad_oh_cnt       (bad_oh_cnt),
        .o_dbg_rr_ptr     (dbg_rr),
        .o_dbg_fifo_count (dbg_count)
    );

    always #5 clk = ~clk;

    // Reference model: slot occupancy per source, an expected FIFO queue, RR pointer, counters.
    logic [RW-1:0] exp_q[$];
    bit            m_full [N];
    logic [RW-1:0] m_rec  [N];
    int            m_drop [N];
    int            m_rr;
    int            m_bad;

    task automatic model_reset();
        exp_q.delete();
        for (int s = 0; s < N; s++) begin
            m_full[s] = 0;
            m_drop[s] = 0;
        end
        m_rr  = 0;
        m_bad = 0;
    endtask

    task automatic model_step();
        int g;
        int idx;
        logic [7:0] w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        g = -1;
        if (exp_q.size() < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && m_full[idx]) g = idx;
            end
        end
        if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back(m_rec[g]);
            m_full[g] = 0;
            m_rr = (g + 1) % N;
        end
        for (int s = 0; s < N; s++) begin
            if (bus.tap_valid[s] && cfg_enable) begin
                w = bus.tap_warp_oh[8*s +: 8];
                if ($countones(w) != 1) begin
                    if (m_bad < CMAX) m_bad++;
                end else if ((w & cfg_warp_mask) == 8'h00) begin
                    // filtered out silently
                end else if (m_full[s]) begin
                    if (m_drop[s] < CMAX) m_drop[s]++;
                end else begin
                    m_full[s] = 1;
                    m_rec[s]  = {3'(s), w, bus.tap_instr[32*s +: 32], bus.tap_pc[32*s +: 32]};
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [RW-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("out_valid", 128'(bus.out_valid), 128'(exp_q.size() != 0));
        chk("out_head", 128'({bus.out_src, bus.out_warp_oh, bus.out_instr, bus.out_pc}), 128'(head));
        chk("fifo_count", 128'(dbg_count), 128'(exp_q.size()));
        chk("rr_ptr", 128'(dbg_rr), 128'(m_rr));
        chk("bad_oh_cnt", 128'(bad_oh_cnt), 128'(m_bad));
        for (int s = 0; s < N; s++) chk("drop_cnt", 128'(drop_cnt[CW*s +: CW]), 128'(m_drop[s]));
    endtask

    task automatic clear_taps();
        bus.tap_valid   = '0;
        bus.tap_warp_oh = '0;
        bus.tap_instr   = '0;
        bus.tap_pc      = '0;
    endtask

    task automatic set_tap(input int s, input logic [7:0] w, input logic [31:0] ins, input logic [31:0] pc);
        bus.tap_valid[s]          = 1'b1;
        bus.tap_warp_oh[8*s +: 8] = w;
        bus.tap_instr[32*s +: 32] = ins;
        bus.tap_pc[32*s +: 32]    = pc;
    endtask

    // One clock: model follows the edge, outputs are checked at the falling edge, taps are strobes.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        clear_taps();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_taps();
        bus.out_ready = 1'b0;
        model_reset();
        step();
        step();
        chk("reset_valid", 128'(bus.out_valid), 128'(0));
        chk("reset_instr", 128'(bus.out_instr), 128'(0));
        rst_n = 1'b1;
        cfg_enable = 1'b1;
        cfg_warp_mask = 8'hFF;

        // Single tap: visible two edges after capture.
        set_tap(1, 8'h04, 32'h2001_0005, 32'h40);
        step();
        chk("single_lat1", 128'(bus.out_valid), 128'(0));
        step();
        chk("single_valid", 128'(bus.out_valid), 128'(1));
        chk("single_src", 128'(bus.out_src), 128'(1));
        chk("single_instr", 128'(bus.out_instr), 128'(32'h2001_0005));
        bus.out_ready = 1'b1;
        step();
        chk("single_empty", 128'(bus.out_valid), 128'(0));

        // All four taps in one cycle drain in source order.
        do_reset();
        for (int s = 0; s < N; s++) set_tap(s, 8'h01, 32'h1000 + 32'(s), 32'h80 + 32'(s));
        step();
        for (int i = 0; i < N; i++) begin
            step();
            chk("rr_order", 128'(bus.out_src), 128'(i));
        end
        step();
        chk("rr_after", 128'(dbg_rr), 128'(0));

        // Overflow: one source, consumer stalled.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_tap(0, 8'h02, 32'h100 + 32'(i), 32'h0);
            step();
        end
        chk("ovf_count", 128'(dbg_count), 128'(8));
        chk("ovf_drop0", 128'(drop_cnt[CW-1:0]), 128'(3));
        step();
        chk("ovf_head_stable", 128'(bus.out_instr), 128'(32'h100));
        bus.out_ready = 1'b1;
        step();
        chk("full_pop_nopush", 128'(dbg_count), 128'(7));
        bus.out_ready = 1'b0;
        step();
        chk("push_resume", 128'(dbg_count), 128'(8));
        chk("push_resume_head", 128'(bus.out_instr), 128'(32'h101));

        // Warp filter and one-hot check.
        do_reset();
        bus.out_ready = 1'b0;
        cfg_warp_mask = 8'h01;
        set_tap(2, 8'h02, 32'hAA, 32'h10);
        step();
        set_tap(2, 8'h01, 32'hBB, 32'h14);
        step();
        step();
        chk("filter_count", 128'(dbg_count), 128'(1));
        chk("filter_instr", 128'(bus.out_instr), 128'(32'hBB));
        set_tap(3, 8'h03, 32'hCC, 32'h18);
        step();
        chk("bad_oh_one", 128'(bad_oh_cnt), 128'(1));
        cfg_warp_mask = 8'hFF;

        // Reset with five records queued.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_tap(0, 8'h10, 32'h500 + 32'(i), 32'h0);
            step();
        end
        chk("pre_reset_count", 128'(dbg_count), 128'(5));
        do_reset();
        chk("midreset_valid", 128'(bus.out_valid), 128'(0));
        chk("midreset_drop", 128'(drop_cnt), 128'(0));
        set_tap(3, 8'h80, 32'h777, 32'h1C);
        step();
        step();
        chk("post_reset_src", 128'(bus.out_src), 128'(3));

        // Randomized traffic with enable, mask and backpressure changes.
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) cfg_warp_mask = 8'($urandom_range(0, 255)) | 8'h01;
            cfg_enable    = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 9) == 0)
                        set_tap(s, 8'($urandom_range(0, 255)), $urandom, $urandom);
                    else
                        set_tap(s, 8'(1 << $urandom_range(0, 7)), $urandom, $urandom);
                end
            end
            if (c == 300) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
